// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY definitions for the Gen1/Gen2 8b/10b-domain datapath.
// Holds the SKP ordered-set symbols, the PIPE byte width and the SKP
// insert/remove state type, which the TX inserter and RX remover both use.
package pcie_phy_pkg;

  localparam logic [7:0] COM_SYM        = 8'hBC;
  localparam logic [7:0] SKP_SYM        = 8'h1C;
  localparam int         PIPE_MAX_BYTES = 4;

  typedef enum logic [0:0] {
    PASS,
    INSERT
  } skp_state_e;

  // Symbol at position idx of a SKP ordered set: COM first, then three SKP.
  function automatic logic [7:0] skp_os_sym(input logic [1:0] idx);
    return (idx == 2'd0) ? COM_SYM : SKP_SYM;
  endfunction

endpackage

// File: rtl/skp_interval_counter.sv
// Symbol-time counter that schedules SKP ordered sets.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        zero the counter and drop all pending sets
//   advance_i      add step_i symbol times this cycle
//   step_i         symbol times elapsed per cycle (1, 2 or 4)
//   dec_i          one pending set has been sent
//   sym_cnt_o      current symbol count (remainder after each interval)
//   pending_o      scheduled but unsent sets, saturating at MAX_PENDING
module skp_interval_counter #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned MAX_PENDING  = 3,
  parameter int unsigned CNT_W        = 12,
  localparam int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              advance_i,
  input  logic [2:0]        step_i,
  input  logic              dec_i,
  output logic [CNT_W-1:0]  sym_cnt_o,
  output logic [PEND_W-1:0] pending_o
);

  logic [CNT_W-1:0]  r_sym_cnt;
  logic [PEND_W-1:0] r_pending;
  logic [CNT_W-1:0]  w_sum;
  logic              w_wrap;

  assign w_sum  = r_sym_cnt + CNT_W'(step_i);
  assign w_wrap = (w_sum >= CNT_W'(SKP_INTERVAL));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_sym_cnt <= '0;
      r_pending <= '0;
    end else if (advance_i) begin
      if (w_wrap) begin
        // Keep the remainder so the long-run SKP rate is exact.
        r_sym_cnt <= w_sum - CNT_W'(SKP_INTERVAL);
        if (r_pending != PEND_W'(MAX_PENDING)) begin
          r_pending <= r_pending + PEND_W'(1);
        end
      end else begin
        r_sym_cnt <= w_sum;
      end
    end else if (dec_i && (r_pending != '0)) begin
      r_pending <= r_pending - PEND_W'(1);
    end
  end

  assign sym_cnt_o = r_sym_cnt;
  assign pending_o = r_pending;

endmodule

// File: rtl/gen1_skp_inserter.sv
// Gen1/Gen2 TX SKP ordered-set inserter, sitting just upstream of the scrambler.
// Forwards the 8b/10b-domain symbol stream and, at packet boundaries, inserts
// COM,SKP,SKP,SKP ordered sets on the schedule kept by skp_interval_counter.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   pipe_width_i     active bits (8, 16 or 32); bytes 0..w-1 carry symbols
//   skp_en_i         SKP scheduling enable (low during training sets)
//   data_in_i        symbols, byte 0 first on the wire
//   data_k_in_i      per-byte K flags
//   data_valid_i     upstream beat valid
//   in_pkt_i         next beat continues a packet; no insertion allowed
//   data_ready_o     beat taken when valid and ready
//   data_out_o       registered symbols to the scrambler
//   data_k_out_o     registered K flags to the scrambler
//   data_valid_o     registered valid to the scrambler
module gen1_skp_inserter
  import pcie_phy_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned MAX_PENDING  = 3,
  parameter int unsigned CNT_W        = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [5:0]  pipe_width_i,
  input  logic        skp_en_i,
  input  logic [31:0] data_in_i,
  input  logic [3:0]  data_k_in_i,
  input  logic        data_valid_i,
  input  logic        in_pkt_i,
  output logic        data_ready_o,
  output logic [31:0] data_out_o,
  output logic [3:0]  data_k_out_o,
  output logic        data_valid_o
);

  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);

  skp_state_e        r_state;
  logic [1:0]        r_set_idx;
  logic [2:0]        r_width;
  logic [31:0]       r_data_out;
  logic [3:0]        r_k_out;
  logic              r_valid_out;

  logic [2:0]        w_pass_bytes;
  logic [2:0]        w_bytes;
  logic [PEND_W-1:0] w_pending;
  logic [CNT_W-1:0]  w_unused_sym_cnt;
  logic              w_unused_width;
  logic              w_start;
  logic              w_emit;
  logic              w_ready;
  logic [1:0]        w_idx_next;
  logic              w_set_done;
  logic              w_stay_insert;
  logic [31:0]       w_skp_data;
  logic [3:0]        w_skp_k;
  logic [31:0]       w_pass_data;
  logic [3:0]        w_pass_k;

  assign w_pass_bytes   = pipe_width_i[5:3];
  assign w_unused_width = ^pipe_width_i[2:0];
  // Width is frozen for the whole insertion so a set never splits oddly.
  assign w_bytes        = (r_state == PASS) ? w_pass_bytes : r_width;

  // The start cycle already emits the first symbols, so it counts as an
  // insertion cycle and the symbol counter is frozen in it.
  assign w_start    = (r_state == PASS) && (w_pending != '0) && !in_pkt_i && skp_en_i;
  assign w_emit     = (r_state == INSERT) || w_start;
  assign w_ready    = (r_state == PASS) && !((w_pending != '0) && !in_pkt_i);
  assign w_idx_next = r_set_idx + w_bytes[1:0];
  assign w_set_done = w_emit && (w_idx_next == 2'd0);
  // pending_o still holds the pre-decrement value here.
  assign w_stay_insert = w_emit &&
                         (!w_set_done || (skp_en_i && (w_pending > PEND_W'(1))));

  skp_interval_counter #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .MAX_PENDING  (MAX_PENDING),
    .CNT_W        (CNT_W)
  ) u_skp_interval_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clear_i   (!skp_en_i),
    .advance_i (skp_en_i && !w_emit),
    .step_i    (w_bytes),
    .dec_i     (w_set_done),
    .sym_cnt_o (w_unused_sym_cnt),
    .pending_o (w_pending)
  );

  always_comb begin
    w_skp_data  = '0;
    w_skp_k     = '0;
    w_pass_data = '0;
    w_pass_k    = '0;
    for (int b = 0; b < PIPE_MAX_BYTES; b++) begin
      if (3'(b) < w_bytes) begin
        w_skp_data[8*b +: 8] = skp_os_sym(r_set_idx + 2'(b));
        w_skp_k[b]           = 1'b1;
      end
      if (3'(b) < w_pass_bytes) begin
        w_pass_data[8*b +: 8] = data_in_i[8*b +: 8];
        w_pass_k[b]           = data_k_in_i[b];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= PASS;
      r_set_idx   <= 2'd0;
      r_width     <= 3'd4;
      r_data_out  <= '0;
      r_k_out     <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (r_state == PASS) begin
        r_width <= w_pass_bytes;
      end
      r_state <= w_stay_insert ? INSERT : PASS;
      if (w_emit) begin
        r_set_idx   <= w_idx_next;
        r_data_out  <= w_skp_data;
        r_k_out     <= w_skp_k;
        r_valid_out <= 1'b1;
      end else if (data_valid_i && w_ready) begin
        r_data_out  <= w_pass_data;
        r_k_out     <= w_pass_k;
        r_valid_out <= 1'b1;
      end else begin
        r_valid_out <= 1'b0;
      end
    end
  end

  assign data_ready_o = w_ready;
  assign data_out_o   = r_data_out;
  assign data_k_out_o = r_k_out;
  assign data_valid_o = r_valid_out;

endmodule
